// File: rtl/vreg_hazard_scoreboard.sv
// Vector-register hazard scoreboard: gates decoder dispatch into instruction slots until
// the instruction is clear of RAW/WAW/WAR hazards and read-counter capacity limits.
module vreg_hazard_scoreboard #(
    parameter int REGISTER_COUNT = 32,
    parameter int SLOT_COUNT     = 2,
    parameter int RD_CNT_W       = 3,
    localparam int SW = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1,
    localparam int RW = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [SW-1:0]             disp_slot,
    input  logic [3:0]                disp_use,
    input  logic [RW-1:0]             disp_vd,
    input  logic [RW-1:0]             disp_vs1,
    input  logic [RW-1:0]             disp_vs2,
    input  logic [RW-1:0]             disp_vs3,
    input  logic [SLOT_COUNT-1:0]     slot_rd_done,
    input  logic [SLOT_COUNT-1:0]     slot_wr_done,
    output logic [SLOT_COUNT-1:0]     slot_busy,
    output logic [REGISTER_COUNT-1:0] wr_pending,
    output logic                      err
);
    // Wide enough for rc + 3 same-cycle increments, or rc minus all slots' decrements.
    localparam int CW = RD_CNT_W + $clog2(3 * SLOT_COUNT + 4) + 1;
    localparam logic [CW-1:0] RC_MAX = {{(CW - RD_CNT_W){1'b0}}, {RD_CNT_W{1'b1}}};

    logic                  r_wp     [REGISTER_COUNT];
    logic [RD_CNT_W-1:0]   r_rc     [REGISTER_COUNT];
    logic [SLOT_COUNT-1:0] r_busy;
    logic [SLOT_COUNT-1:0] r_rd_open;
    logic [SLOT_COUNT-1:0] r_wr_open;
    logic [3:0]            r_use    [SLOT_COUNT];
    logic [RW-1:0]         r_idx    [SLOT_COUNT][4];
    logic                  r_err;

    logic [RW-1:0]         w_idx     [4];
    logic                  w_wp_next [REGISTER_COUNT];
    logic [RD_CNT_W-1:0]   w_rc_next [REGISTER_COUNT];
    logic [SLOT_COUNT-1:0] w_rd_fire;
    logic [SLOT_COUNT-1:0] w_wr_fire;
    logic                  w_bad_done;
    logic                  w_ready;
    logic                  w_issue;
    logic [CW-1:0]         w_dup;

    // Field 0 is vd; fields 1..3 are the sources, aligned with disp_use bits.
    assign w_idx[0] = disp_vd;
    assign w_idx[1] = disp_vs1;
    assign w_idx[2] = disp_vs2;
    assign w_idx[3] = disp_vs3;

    assign w_rd_fire  = slot_rd_done & r_rd_open;
    assign w_wr_fire  = slot_wr_done & r_wr_open;
    assign w_bad_done = |(slot_rd_done & ~r_rd_open) | |(slot_wr_done & ~r_wr_open);
    assign w_issue    = disp_valid & w_ready;

    always_comb begin
        w_ready = ~r_busy[disp_slot];
        w_dup   = '0;
        if (disp_use[0] && (r_wp[disp_vd] || (r_rc[disp_vd] != '0))) begin
            w_ready = 1'b0;
        end
        for (int k = 1; k < 4; k++) begin
            if (disp_use[k]) begin
                w_dup = '0;
                for (int j = 1; j < 4; j++) begin
                    if (disp_use[j] && (w_idx[j] == w_idx[k])) begin
                        w_dup = w_dup + CW'(1);
                    end
                end
                if (r_wp[w_idx[k]]) begin
                    w_ready = 1'b0;
                end
                if (({{(CW - RD_CNT_W){1'b0}}, r_rc[w_idx[k]]} + w_dup) > RC_MAX) begin
                    w_ready = 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REGISTER_COUNT; gi++) begin : g_reg
            logic [CW-1:0] w_inc;
            logic [CW-1:0] w_dec;
            logic          w_wp_set;
            logic          w_wp_clr;

            always_comb begin
                w_inc    = '0;
                w_dec    = '0;
                w_wp_set = w_issue && disp_use[0] && (disp_vd == RW'(gi));
                w_wp_clr = 1'b0;
                for (int k = 1; k < 4; k++) begin
                    if (w_issue && disp_use[k] && (w_idx[k] == RW'(gi))) begin
                        w_inc = w_inc + CW'(1);
                    end
                end
                for (int s = 0; s < SLOT_COUNT; s++) begin
                    for (int k = 1; k < 4; k++) begin
                        if (w_rd_fire[s] && r_use[s][k] && (r_idx[s][k] == RW'(gi))) begin
                            w_dec = w_dec + CW'(1);
                        end
                    end
                    if (w_wr_fire[s] && r_use[s][0] && (r_idx[s][0] == RW'(gi))) begin
                        w_wp_clr = 1'b1;
                    end
                end
            end

            // Issue and retire on the same register in one cycle net out.
            assign w_rc_next[gi] = RD_CNT_W'(({{(CW - RD_CNT_W){1'b0}}, r_rc[gi]} + w_inc) - w_dec);
            assign w_wp_next[gi] = w_wp_set | (r_wp[gi] & ~w_wp_clr);
            assign wr_pending[gi] = r_wp[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                r_wp[r] <= 1'b0;
                r_rc[r] <= '0;
            end
        end else begin
            for (int r = 0; r < REGISTER_COUNT; r++) begin
                r_wp[r] <= w_wp_next[r];
                r_rc[r] <= w_rc_next[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= '0;
            r_rd_open <= '0;
            r_wr_open <= '0;
            r_err     <= 1'b0;
            for (int s = 0; s < SLOT_COUNT; s++) begin
                r_use[s] <= '0;
                for (int k = 0; k < 4; k++) begin
                    r_idx[s][k] <= '0;
                end
            end
        end else begin
            r_err <= r_err | w_bad_done;
            for (int s = 0; s < SLOT_COUNT; s++) begin
                if (w_issue && (disp_slot == SW'(s))) begin
                    r_busy[s]    <= 1'b1;
                    r_rd_open[s] <= |disp_use[3:1];
                    r_wr_open[s] <= disp_use[0];
                    r_use[s]     <= disp_use;
                    for (int k = 0; k < 4; k++) begin
                        r_idx[s][k] <= w_idx[k];
                    end
                end else begin
                    // Entry frees in the same cycle its last open bit closes.
                    r_rd_open[s] <= r_rd_open[s] & ~w_rd_fire[s];
                    r_wr_open[s] <= r_wr_open[s] & ~w_wr_fire[s];
                    r_busy[s]    <= r_busy[s] & ((r_rd_open[s] & ~w_rd_fire[s]) |
                                                 (r_wr_open[s] & ~w_wr_fire[s]));
                end
            end
        end
    end

    assign disp_ready = w_ready;
    assign slot_busy  = r_busy;
    assign err        = r_err;

endmodule

// File: tb/tb_vreg_hazard_scoreboard.sv
// Bench for vreg_hazard_scoreboard: instruction-level model of in-flight slots, compared
// every cycle, plus directed hazard scenarios with literal expectations.
module tb_vreg_hazard_scoreboard;
    localparam int NREG = 32;
    localparam int NSLOT = 4;
    localparam int RCW = 2;

    logic             clk;
    logic             rst;
    logic             disp_valid;
    logic             disp_ready;
    logic [1:0]       disp_slot;
    logic [3:0]       disp_use;
    logic [4:0]       disp_vd, disp_vs1, disp_vs2, disp_vs3;
    logic [NSLOT-1:0] slot_rd_done, slot_wr_done, slot_busy;
    logic [NREG-1:0]  wr_pending;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    vreg_hazard_scoreboard #(.REGISTER_COUNT(NREG), .SLOT_COUNT(NSLOT), .RD_CNT_W(RCW)) dut (
        .clk(clk), .rst(rst), .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_slot(disp_slot), .disp_use(disp_use), .disp_vd(disp_vd), .disp_vs1(disp_vs1),
        .disp_vs2(disp_vs2), .disp_vs3(disp_vs3), .slot_rd_done(slot_rd_done),
        .slot_wr_done(slot_wr_done), .slot_busy(slot_busy), .wr_pending(wr_pending), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the set of in-flight instructions; register state is derived by scanning them.
    bit       m_busy [NSLOT];
    bit       m_rd   [NSLOT];
    bit       m_wr   [NSLOT];
    bit [3:0] m_use  [NSLOT];
    int       m_reg  [NSLOT][4];
    bit       m_err;

    function automatic int cur_idx(int k);
        case (k)
            0: return int'(disp_vd);
            1: return int'(disp_vs1);
            2: return int'(disp_vs2);
            default: return int'(disp_vs3);
        endcase
    endfunction

    function automatic bit m_wp(int r);
        for (int s = 0; s < NSLOT; s++)
            if (m_wr[s] && m_reg[s][0] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_rc(int r);
        int n = 0;
        for (int s = 0; s < NSLOT; s++)
            if (m_rd[s])
                for (int k = 1; k < 4; k++)
                    if (m_use[s][k] && m_reg[s][k] == r) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        if (m_busy[disp_slot]) return 1'b0;
        if (disp_use[0] && (m_wp(cur_idx(0)) || m_rc(cur_idx(0)) != 0)) return 1'b0;
        for (int k = 1; k < 4; k++) begin
            if (disp_use[k]) begin
                int dup = 0;
                for (int j = 1; j < 4; j++)
                    if (disp_use[j] && cur_idx(j) == cur_idx(k)) dup++;
                if (m_wp(cur_idx(k))) return 1'b0;
                if (m_rc(cur_idx(k)) + dup > (1 << RCW) - 1) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int s = 0; s < NSLOT; s++) v[s] = m_busy[s];
        return v;
    endfunction

    function automatic logic [31:0] m_wp_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_wp(r);
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSLOT; s++) begin
                m_busy[s] = 0; m_rd[s] = 0; m_wr[s] = 0; m_use[s] = '0;
            end
            m_err = 0;
        end else begin
            bit issue;
            issue = disp_valid && m_ready();
            for (int s = 0; s < NSLOT; s++) begin
                if (slot_rd_done[s]) begin
                    if (m_rd[s]) m_rd[s] = 0; else m_err = 1;
                end
                if (slot_wr_done[s]) begin
                    if (m_wr[s]) m_wr[s] = 0; else m_err = 1;
                end
                if (m_busy[s] && !m_rd[s] && !m_wr[s]) m_busy[s] = 0;
            end
            if (issue) begin
                m_busy[disp_slot] = 1;
                m_rd[disp_slot]   = |disp_use[3:1];
                m_wr[disp_slot]   = disp_use[0];
                m_use[disp_slot]  = disp_use;
                for (int k = 0; k < 4; k++) m_reg[disp_slot][k] = cur_idx(k);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_ready", {31'b0, disp_ready}, {31'b0, m_ready()});
        chk("m_busy", {28'b0, slot_busy}, m_busy_vec());
        chk("m_wrpend", wr_pending, m_wp_vec());
        chk("m_err", {31'b0, err}, {31'b0, m_err});
    end

    task automatic set_disp(input bit v, input int slot, input logic [3:0] u,
                            input int vd, input int s1, input int s2, input int s3);
        disp_valid = v;
        disp_slot  = 2'(slot);
        disp_use   = u;
        disp_vd    = 5'(vd);
        disp_vs1   = 5'(s1);
        disp_vs2   = 5'(s2);
        disp_vs3   = 5'(s3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        slot_rd_done = '0;
        slot_wr_done = '0;
    endtask

    initial begin
        rst = 1'b1;
        slot_rd_done = '0;
        slot_wr_done = '0;
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_busy", {28'b0, slot_busy}, 32'h0);
        chk("rst_wp", wr_pending, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);

        // vadd v3,v1,v2 -> slot 0
        set_disp(1, 0, 4'b0111, 3, 1, 2, 0);
        #1 chk("vadd_ready", {31'b0, disp_ready}, 32'h1);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        #1;
        chk("vadd_wp", wr_pending, 32'h0000_0008);
        chk("vadd_busy", {28'b0, slot_busy}, 32'h1);

        // RAW: vadd v4,v3,v5 -> slot 1 waits for slot 0's write of v3
        set_disp(1, 1, 4'b0111, 4, 3, 5, 0);
        #1 chk("raw_stall", {31'b0, disp_ready}, 32'h0);
        tick();
        slot_wr_done = 4'b0001;
        #1 chk("raw_same", {31'b0, disp_ready}, 32'h0);
        tick();
        #1 chk("raw_next", {31'b0, disp_ready}, 32'h1);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);

        // WAR: slot 2 reads v7, slot 3 wants to write v7
        set_disp(1, 2, 4'b0010, 0, 7, 0, 0);
        tick();
        set_disp(1, 3, 4'b0001, 7, 0, 0, 0);
        #1 chk("war_stall", {31'b0, disp_ready}, 32'h0);
        tick();
        slot_rd_done = 4'b0100;
        #1 chk("war_same", {31'b0, disp_ready}, 32'h0);
        tick();
        #1 chk("war_next", {31'b0, disp_ready}, 32'h1);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);

        // Retire everything; slot 1 finishes read and write in the same cycle
        slot_rd_done = 4'b0011;
        slot_wr_done = 4'b1010;
        tick();
        #1;
        chk("drain_busy", {28'b0, slot_busy}, 32'h0);
        chk("drain_wp", wr_pending, 32'h0);
        chk("drain_err", {31'b0, err}, 32'h0);

        // Capacity with 2-bit counters: rc[5]=2, then vs1=vs2=v5
        set_disp(1, 0, 4'b0010, 0, 5, 0, 0);
        tick();
        set_disp(1, 1, 4'b0010, 0, 5, 0, 0);
        tick();
        set_disp(1, 2, 4'b0110, 0, 5, 5, 0);
        #1 chk("cap_stall", {31'b0, disp_ready}, 32'h0);
        tick();
        slot_rd_done = 4'b0001;
        #1 chk("cap_same", {31'b0, disp_ready}, 32'h0);
        tick();
        #1 chk("cap_next", {31'b0, disp_ready}, 32'h1);
        tick();
        set_disp(1, 0, 4'b0010, 0, 5, 0, 0);
        slot_rd_done = 4'b0010;
        #1 chk("cap_full", {31'b0, disp_ready}, 32'h0);
        tick();
        #1 chk("cap_free", {31'b0, disp_ready}, 32'h1);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        slot_rd_done = 4'b0101;
        tick();
        #1 chk("cap_drain", {28'b0, slot_busy}, 32'h0);

        // Stray write-done on idle slot 1
        slot_wr_done = 4'b0010;
        tick();
        #1;
        chk("err_set", {31'b0, err}, 32'h1);
        chk("err_wp", wr_pending, 32'h0);
        chk("err_busy", {28'b0, slot_busy}, 32'h0);

        // All-zero use mask: busy for exactly one cycle
        set_disp(1, 3, 4'b0000, 0, 0, 0, 0);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        #1 chk("zero_busy1", {28'b0, slot_busy}, 32'h8);
        tick();
        #1 chk("zero_busy0", {28'b0, slot_busy}, 32'h0);

        // Reset mid-flight
        set_disp(1, 0, 4'b0001, 9, 0, 0, 0);
        tick();
        set_disp(1, 1, 4'b0011, 10, 11, 0, 0);
        tick();
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        #1;
        chk("mid_wp", wr_pending, 32'h0000_0600);
        chk("mid_busy", {28'b0, slot_busy}, 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst2_busy", {28'b0, slot_busy}, 32'h0);
        chk("rst2_wp", wr_pending, 32'h0);
        chk("rst2_err", {31'b0, err}, 32'h0);
        chk("rst2_ready", {31'b0, disp_ready}, 32'h1);

        // Mixed traffic over a small register window, checked by the model each cycle
        for (int i = 0; i < 400; i++) begin
            set_disp(($urandom_range(0, 3) != 0), $urandom_range(0, 3), 4'($urandom_range(0, 15)),
                     $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5));
            for (int s = 0; s < NSLOT; s++) begin
                slot_rd_done[s] = ($urandom_range(0, 5) == 0) && m_rd[s];
                slot_wr_done[s] = ($urandom_range(0, 5) == 0) && m_wr[s];
            end
            tick();
        end
        set_disp(0, 0, 4'b0000, 0, 0, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
